// File: rtl/dac_spi_writer.sv
// Serialises one data word per frame to a SPI DAC: 32-bit frame, MSB first, sclk idles high,
// nsync low for the whole frame. One-deep pending register keeps only the newest word.
module dac_spi_writer #(
    parameter int         W_DATA      = 16,
    parameter logic [3:0] CMD         = 4'h3,
    parameter logic [3:0] CHAN_ADDR   = 4'h0,
    parameter int         HALF_PERIOD = 2,
    parameter int         NSYNC_HIGH  = 2
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [W_DATA-1:0] data_in,
    input  logic              data_valid_in,
    output logic              dac_sclk_out,
    output logic              dac_din_out,
    output logic              dac_nsync_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              overflow_out
);
    localparam int BIT_CYC = 2 * HALF_PERIOD;
    localparam int PH_W    = $clog2(BIT_CYC);
    localparam int HOLD_W  = (NSYNC_HIGH > 1) ? $clog2(NSYNC_HIGH) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BIT_CYC - 1);
    localparam logic [PH_W-1:0]   PH_FALL   = PH_W'(HALF_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NSYNC_HIGH - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_HOLD = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [31:0]         shreg;
    logic [4:0]          bit_cnt;
    logic [PH_W-1:0]     ph_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [W_DATA-1:0]   pend_data;
    logic                pend_vld;
    logic                ovf_q;
    logic                bit_end, frame_end, hold_end;
    logic                launch, capture;
    logic [W_DATA-1:0]   launch_data;

    // Narrow words sit at the top of the 16-bit field with zero-filled LSBs.
    function automatic logic [31:0] make_frame(input logic [W_DATA-1:0] d);
        logic [15:0] f;
        f = '0;
        f[15 -: W_DATA] = d;
        return {4'b0000, CMD, CHAN_ADDR, f, 4'b0000};
    endfunction

    assign bit_end     = (ph_cnt == PH_LAST);
    assign frame_end   = bit_end && (bit_cnt == 5'd31);
    assign hold_end    = (hold_cnt == HOLD_LAST);
    assign launch      = ((state == ST_IDLE) && data_valid_in) ||
                         ((state == ST_HOLD) && hold_end && (data_valid_in || pend_vld));
    assign capture     = data_valid_in &&
                         ((state == ST_SHIFT) || ((state == ST_HOLD) && !hold_end));
    // A fresh strobe always wins over the pending word.
    assign launch_data = data_valid_in ? data_in : pend_data;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (data_valid_in) state_nxt = ST_SHIFT;
            ST_SHIFT: if (frame_end) state_nxt = ST_HOLD;
            ST_HOLD:  if (hold_end) state_nxt = launch ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            ph_cnt    <= '0;
            hold_cnt  <= '0;
            pend_data <= '0;
            pend_vld  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (launch) begin
                shreg    <= make_frame(launch_data);
                bit_cnt  <= '0;
                ph_cnt   <= '0;
                pend_vld <= 1'b0;
                ovf_q    <= pend_vld && data_valid_in;
            end else if (state == ST_SHIFT) begin
                hold_cnt <= '0;
                if (bit_end) begin
                    ph_cnt  <= '0;
                    shreg   <= {shreg[30:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                end else begin
                    ph_cnt <= ph_cnt + 1'b1;
                end
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (capture) begin
                pend_data <= data_in;
                pend_vld  <= 1'b1;
                ovf_q     <= pend_vld;
            end
        end
    end

    always_comb begin
        dac_nsync_out = 1'b1;
        dac_sclk_out  = 1'b1;
        dac_din_out   = 1'b0;
        if (state == ST_SHIFT) begin
            dac_nsync_out = 1'b0;
            dac_sclk_out  = (ph_cnt < PH_FALL);
            dac_din_out   = shreg[31];
        end
        done_out     = (state == ST_HOLD) && (hold_cnt == '0);
        busy_out     = (state != ST_IDLE) || pend_vld;
        overflow_out = ovf_q;
    end
endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: two instances (slow and fastest timing), a frame decoder per
// instance, and an event-level model predicting which words are sent and when.
module tb_dac_spi_writer;
    localparam int HPV[2]  = '{2, 1};
    localparam int NHV[2]  = '{2, 1};
    localparam int PERV[2] = '{64 * 2 + 2, 64 * 1 + 1};

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        reset_in;
    logic [15:0] data_a, data_b;
    logic        vld_a, vld_b;
    logic        sclk_a, din_a, nsync_a, busy_a, done_a, ovf_a;
    logic        sclk_b, din_b, nsync_b, busy_b, done_b, ovf_b;

    dac_spi_writer #(.W_DATA(16), .CMD(4'h3), .CHAN_ADDR(4'h0), .HALF_PERIOD(2), .NSYNC_HIGH(2)) dut_a (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_a), .data_valid_in(vld_a),
        .dac_sclk_out(sclk_a), .dac_din_out(din_a), .dac_nsync_out(nsync_a),
        .busy_out(busy_a), .done_out(done_a), .overflow_out(ovf_a));

    dac_spi_writer #(.W_DATA(16), .CMD(4'h3), .CHAN_ADDR(4'h0), .HALF_PERIOD(1), .NSYNC_HIGH(1)) dut_b (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_b), .data_valid_in(vld_b),
        .dac_sclk_out(sclk_b), .dac_din_out(din_b), .dac_nsync_out(nsync_b),
        .busy_out(busy_b), .done_out(done_b), .overflow_out(ovf_b));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model state: one frame slot plus one pending word per instance.
    int          m_active[2], m_L[2], m_pend[2], m_ovf[2], launches[2];
    logic [15:0] m_pendw[2];
    logic        exp_have[2];
    logic [15:0] exp_w[2];
    int          exp_L[2];

    task automatic m_launch(input int i, input logic [15:0] w);
        check($sformatf("frame_missing%0d", i), exp_have[i], 1'b0);
        exp_have[i] = 1'b1;
        exp_w[i]    = w;
        exp_L[i]    = cyc;
        m_active[i] = 1;
        m_L[i]      = cyc;
        launches[i]++;
    endtask

    task automatic model_step(input int i, input logic v, input logic [15:0] w);
        if (m_active[i] != 0 && cyc == m_L[i] + PERV[i]) begin
            if (v) begin
                if (m_pend[i] != 0) m_ovf[i]++;
                m_pend[i] = 0;
                m_launch(i, w);
            end else if (m_pend[i] != 0) begin
                m_pend[i] = 0;
                m_launch(i, m_pendw[i]);
            end else begin
                m_active[i] = 0;
            end
        end else if (m_active[i] != 0) begin
            if (v) begin
                if (m_pend[i] != 0) m_ovf[i]++;
                m_pend[i]  = 1;
                m_pendw[i] = w;
            end
        end else if (v) begin
            m_launch(i, w);
        end
    endtask

    task automatic model_reset(input int i);
        if (exp_have[i] === 1'b1) launches[i]--;
        exp_have[i] = 1'b0;
        m_active[i] = 0;
        m_pend[i]   = 0;
    endtask

    always @(posedge clk_in) begin
        if (!reset_in) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, vld_a, data_a);
            model_step(1, vld_b, data_b);
        end
    end

    // Frame decoder: din sampled on each sclk falling edge while nsync is low.
    logic        np[2], sp[2];
    int          nbits[2], low[2], fall_c[2], prev_fall[2], rise_c[2], gap_hi[2];
    int          last_low[2], frames[2], dones[2], ovfs[2];
    logic [31:0] word[2], last_frame[2];

    task automatic mon_step(input int i, input logic ns, input logic sc, input logic di,
                            input logic dn, input logic ov, input logic bz);
        logic fe;
        fe = ns && !np[i];
        check($sformatf("done_pulse%0d", i), dn, fe);
        check($sformatf("busy%0d", i), bz, (m_active[i] != 0) || (m_pend[i] != 0));
        if (ns) begin
            check($sformatf("idle_sclk%0d", i), sc, 1'b1);
            check($sformatf("idle_din%0d", i), di, 1'b0);
        end
        if (!ns) begin
            if (np[i]) begin
                prev_fall[i] = fall_c[i];
                fall_c[i]    = cyc;
                gap_hi[i]    = cyc - rise_c[i];
                nbits[i]     = 0;
                low[i]       = 0;
                word[i]      = '0;
                if (exp_have[i]) check($sformatf("frame_start_cyc%0d", i), cyc, exp_L[i] + 1);
                else check($sformatf("frame_expected%0d", i), exp_have[i], 1'b1);
            end
            low[i]++;
            if (sp[i] && !sc) begin
                word[i] = {word[i][30:0], di};
                nbits[i]++;
            end
        end else if (fe) begin
            frames[i]++;
            last_frame[i] = word[i];
            last_low[i]   = low[i];
            rise_c[i]     = cyc;
            check($sformatf("frame_bits%0d", i), nbits[i], 32);
            check($sformatf("nsync_low%0d", i), low[i], 64 * HPV[i]);
            check($sformatf("frame_word%0d", i), word[i], {4'h0, 4'h3, 4'h0, exp_w[i], 4'h0});
            exp_have[i] = 1'b0;
        end
        if (dn) dones[i]++;
        if (ov) ovfs[i]++;
        np[i] = ns;
        sp[i] = sc;
    endtask

    task automatic mon_reset(input int i, input logic ns, input logic sc, input logic di,
                             input logic dn, input logic ov, input logic bz);
        check($sformatf("rst_nsync%0d", i), ns, 1'b1);
        check($sformatf("rst_sclk%0d", i), sc, 1'b1);
        check($sformatf("rst_din%0d", i), di, 1'b0);
        check($sformatf("rst_busy%0d", i), bz, 1'b0);
        check($sformatf("rst_done%0d", i), dn, 1'b0);
        check($sformatf("rst_ovf%0d", i), ov, 1'b0);
        np[i] = 1'b1;
        sp[i] = 1'b1;
    endtask

    always @(negedge clk_in) begin
        if (!reset_in) begin
            mon_reset(0, nsync_a, sclk_a, din_a, done_a, ovf_a, busy_a);
            mon_reset(1, nsync_b, sclk_b, din_b, done_b, ovf_b, busy_b);
        end else begin
            mon_step(0, nsync_a, sclk_a, din_a, done_a, ovf_a, busy_a);
            mon_step(1, nsync_b, sclk_b, din_b, done_b, ovf_b, busy_b);
        end
    end

    // Strobe w so that it is sampled g clock edges after the previous strobe's edge.
    task automatic strobe(input int i, input logic [15:0] w, input int g);
        repeat (g - 1) @(posedge clk_in);
        #1;
        if (i == 0) begin data_a = w; vld_a = 1'b1; end
        else begin data_b = w; vld_b = 1'b1; end
        @(posedge clk_in);
        #1;
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic count_busy(input int i, output int bc);
        bc = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_in);
            if ((i == 0 ? busy_a : busy_b) == 1'b1) bc++;
            else break;
        end
    endtask

    task automatic wait_frames(input int i, input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk_in);
            if (frames[i] >= target) break;
        end
        if (k == budget) check($sformatf("wait_frames_timeout%0d", i), frames[i], target);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    typedef struct {
        logic [15:0] data;
        logic [31:0] frame;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int f0, d0, o0, bc;
        tbl[0] = '{16'hA5C3, 32'h030A5C30};
        tbl[1] = '{16'h0000, 32'h03000000};
        tbl[2] = '{16'hFFFF, 32'h030FFFF0};
        tbl[3] = '{16'h8001, 32'h03080010};

        reset_in = 1'b0;
        vld_a = 1'b0; vld_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b1;
        repeat (3) @(posedge clk_in);

        // Single words from idle.
        for (int i = 0; i < 4; i++) begin
            f0 = frames[0]; d0 = dones[0];
            strobe(0, tbl[i].data, 1);
            count_busy(0, bc);
            check("tbl_frame", last_frame[0], tbl[i].frame);
            check("tbl_low", last_low[0], 128);
            check("tbl_busy_cycles", bc, 130);
            check("tbl_frames", frames[0] - f0, 1);
            check("tbl_done", dones[0] - d0, 1);
            repeat (5) @(posedge clk_in);
        end

        // Back-to-back via pending.
        f0 = frames[0]; o0 = ovfs[0];
        strobe(0, 16'h1234, 1);
        strobe(0, 16'h5678, 10);
        wait_frames(0, f0 + 2, 600);
        check("b2b_period", fall_c[0] - prev_fall[0], 130);
        check("b2b_word2", last_frame[0], 32'h03056780);
        count_busy(0, bc);
        repeat (4) @(posedge clk_in);
        check("b2b_ovf", ovfs[0] - o0, 0);

        // Three strobes: second is overwritten by third.
        f0 = frames[0]; o0 = ovfs[0];
        strobe(0, 16'h0001, 1);
        strobe(0, 16'h0002, 20);
        strobe(0, 16'h0003, 20);
        wait_frames(0, f0 + 1, 400);
        check("ovw_word1", last_frame[0], 32'h03000010);
        wait_frames(0, f0 + 2, 400);
        check("ovw_word2", last_frame[0], 32'h03000030);
        count_busy(0, bc);
        repeat (4) @(posedge clk_in);
        check("ovw_frames", frames[0] - f0, 2);
        check("ovw_ovf", ovfs[0] - o0, 1);

        // Pending plus strobe on the last hold cycle.
        f0 = frames[0]; o0 = ovfs[0];
        strobe(0, 16'h1111, 1);
        strobe(0, 16'h00AA, 20);
        strobe(0, 16'h00BB, 110);
        wait_frames(0, f0 + 2, 600);
        check("sim_word2", last_frame[0], 32'h03000BB0);
        check("sim_period", fall_c[0] - prev_fall[0], 130);
        count_busy(0, bc);
        repeat (200) @(posedge clk_in);
        check("sim_frames", frames[0] - f0, 2);
        check("sim_ovf", ovfs[0] - o0, 1);

        // Reset during bit 10.
        f0 = frames[0]; d0 = dones[0];
        strobe(0, 16'hFFFF, 1);
        repeat (41) @(posedge clk_in);
        check("rst_midframe_active", nsync_a, 1'b0);
        #1 reset_in = 1'b0;
        #1;
        check("rst_imm_nsync", nsync_a, 1'b1);
        check("rst_imm_sclk", sclk_a, 1'b1);
        check("rst_imm_busy", busy_a, 1'b0);
        check("rst_imm_din", din_a, 1'b0);
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b1;
        repeat (20) @(posedge clk_in);
        check("rst_no_frame", frames[0] - f0, 0);
        check("rst_no_done", dones[0] - d0, 0);
        check("rst_idle_busy", busy_a, 1'b0);
        strobe(0, 16'hA5C3, 1);
        count_busy(0, bc);
        check("rst_next_frame", last_frame[0], 32'h030A5C30);
        check("rst_next_frames", frames[0] - f0, 1);
        check("rst_next_busy", bc, 130);

        // Fastest timing, continuous frames.
        f0 = frames[1];
        strobe(1, 16'h4321, 1);
        strobe(1, 16'h0F0F, 5);
        strobe(1, 16'h7E7E, 70);
        wait_frames(1, f0 + 3, 400);
        check("fast_low", last_low[1], 64);
        check("fast_gap_high", gap_hi[1], 1);
        check("fast_period", fall_c[1] - prev_fall[1], 65);
        check("fast_word3", last_frame[1], 32'h0307E7E0);
        count_busy(1, bc);

        // Randomized traffic, dense and sparse phases.
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 2500; k++) begin
                @(posedge clk_in);
                #1;
                vld_a  = ($urandom_range(0, (ph % 2 == 0) ? 40 : 500) == 0);
                data_a = 16'($urandom);
                vld_b  = ($urandom_range(0, (ph % 2 == 0) ? 20 : 250) == 0);
                data_b = 16'($urandom);
            end
        end
        @(posedge clk_in);
        #1 vld_a = 1'b0; vld_b = 1'b0;
        count_busy(0, bc);
        count_busy(1, bc);
        repeat (5) @(posedge clk_in);
        check("rand_ovf_a", ovfs[0], m_ovf[0]);
        check("rand_ovf_b", ovfs[1], m_ovf[1]);
        check("rand_frames_a", frames[0], launches[0]);
        check("rand_frames_b", frames[1], launches[1]);
        check("rand_dones_a", dones[0], frames[0]);
        check("rand_dones_b", dones[1], frames[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
